regfile_fwd_hilo: RTL

//  Parametrised GPR file plus HI/LO pair for the 5-stage MIPS core, read in ID.

---
 rtl/regfile_fwd_hilo_if.sv | 69 ++++++
 rtl/regfile_fwd_hilo.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/regfile_fwd_hilo_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_fwd_hilo_if
//  Description : Bundle of ID-stage register-file signals: GPR read ports,
//                in-flight forwarding stages, WB write port, HI/LO access,
//                mul/div tracking and the resulting stall.
//                slave  = register file side, master = pipeline side.
//  Ports       : (interface, no ports) parameters DW, AW, NRD, NFWD
//  Revision    : 1.0  initial release
// ============================================================================
interface regfile_fwd_hilo_if #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 2
);
    // GPR read ports
    logic [NRD-1:0]       rd_en;
    logic [NRD*AW-1:0]    raddr;
    logic [NRD*DW-1:0]    rdata;
    // In-flight stages (index 0 = youngest)
    logic [NFWD-1:0]      fwd_we;
    logic [NFWD-1:0]      fwd_ld;
    logic [NFWD*AW-1:0]   fwd_waddr;
    logic [NFWD*DW-1:0]   fwd_wdata;
    logic [NFWD*2-1:0]    fwd_hilo_we;
    logic [NFWD*DW-1:0]   fwd_hi_wdata;
    logic [NFWD*DW-1:0]   fwd_lo_wdata;
    // WB write port
    logic                 we;
    logic [AW-1:0]        waddr;
    logic [DW-1:0]        wdata;
    logic [1:0]           wb_hilo_we;
    logic [DW-1:0]        wb_hi_wdata;
    logic [DW-1:0]        wb_lo_wdata;
    // HI/LO read
    logic                 hilo_re;
    logic                 hilo_rsel;
    logic [DW-1:0]        hilo_rdata;
    // Mul/div unit
    logic                 md_start;
    logic                 md_done;
    logic [DW-1:0]        md_hi;
    logic [DW-1:0]        md_lo;
    logic                 md_busy;
    // Hazard
    logic                 stall;

    modport slave (
        input  rd_en, raddr,
        input  fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
        input  fwd_hilo_we, fwd_hi_wdata, fwd_lo_wdata,
        input  we, waddr, wdata, wb_hilo_we, wb_hi_wdata, wb_lo_wdata,
        input  hilo_re, hilo_rsel,
        input  md_start, md_done, md_hi, md_lo,
        output rdata, hilo_rdata, md_busy, stall
    );

    modport master (
        output rd_en, raddr,
        output fwd_we, fwd_ld, fwd_waddr, fwd_wdata,
        output fwd_hilo_we, fwd_hi_wdata, fwd_lo_wdata,
        output we, waddr, wdata, wb_hilo_we, wb_hi_wdata, wb_lo_wdata,
        output hilo_re, hilo_rsel,
        output md_start, md_done, md_hi, md_lo,
        input  rdata, hilo_rdata, md_busy, stall
    );
endinterface
`default_nettype wire

// File: rtl/regfile_fwd_hilo.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_fwd_hilo
//  Description : GPR file plus HI/LO pair read in ID, with forwarding from
//                NFWD in-flight stages and the WB port, mul/div busy tracking
//                and stall generation (load-use, HI/LO read while busy).
//  Ports       : clk     - clock, all state on posedge
//                resetn  - asynchronous active-low reset
//                bus     - regfile_fwd_hilo_if.slave (reads, forwarding,
//                          WB writes, HI/LO, mul/div, stall)
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_fwd_hilo #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NFWD = 2
) (
    input  wire                    clk,
    input  wire                    resetn,
    regfile_fwd_hilo_if.slave      bus
);

    localparam int NREG = 2**AW;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    logic [DW-1:0]  regs_q [NREG];
    logic [DW-1:0]  hi_q, hi_d;
    logic [DW-1:0]  lo_q, lo_d;
    md_state_t      state_q, state_d;
    logic [NRD-1:0] w_lu;

    // ------------------------------------------------------------------
    // GPR read ports with bypass
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        logic          w_ld;

        assign w_addr = bus.raddr[p*AW +: AW];

        always_comb begin
            w_data = regs_q[w_addr];
            w_ld   = 1'b0;
            if (bus.we && bus.waddr == w_addr) begin
                w_data = bus.wdata;
            end
            // Walk oldest to youngest so the youngest matching stage wins;
            // its load flag decides the hazard, so a younger ALU writer
            // shadows an older load to the same register.
            for (int s = NFWD-1; s >= 0; s--) begin
                if (bus.fwd_we[s] && bus.fwd_waddr[s*AW +: AW] == w_addr) begin
                    w_data = bus.fwd_wdata[s*DW +: DW];
                    w_ld   = bus.fwd_ld[s];
                end
            end
            if (w_addr == '0) begin
                w_data = '0;
                w_ld   = 1'b0;
            end
        end

        assign bus.rdata[p*DW +: DW] = w_data;
        assign w_lu[p]               = bus.rd_en[p] && w_ld;
    end

    // ------------------------------------------------------------------
    // HI/LO read with per-field bypass
    // ------------------------------------------------------------------
    always_comb begin
        logic [DW-1:0] v;
        v = bus.hilo_rsel ? hi_q : lo_q;
        if (bus.wb_hilo_we[bus.hilo_rsel]) begin
            v = bus.hilo_rsel ? bus.wb_hi_wdata : bus.wb_lo_wdata;
        end
        for (int s = NFWD-1; s >= 0; s--) begin
            if (bus.fwd_hilo_we[2*s + int'(bus.hilo_rsel)]) begin
                v = bus.hilo_rsel ? bus.fwd_hi_wdata[s*DW +: DW]
                                  : bus.fwd_lo_wdata[s*DW +: DW];
            end
        end
        bus.hilo_rdata = v;
    end

    // ------------------------------------------------------------------
    // GPR array
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (bus.we && bus.waddr != '0) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    // ------------------------------------------------------------------
    // HI/LO registers: WB is younger than the mul/div result, so it wins
    // ------------------------------------------------------------------
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (bus.md_done) begin
            hi_d = bus.md_hi;
            lo_d = bus.md_lo;
        end
        if (bus.wb_hilo_we[1]) hi_d = bus.wb_hi_wdata;
        if (bus.wb_hilo_we[0]) lo_d = bus.wb_lo_wdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    // ------------------------------------------------------------------
    // Mul/div busy FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.md_start) state_d = ST_BUSY;
            // A start in the done cycle is a back-to-back op: stay busy.
            ST_BUSY: if (bus.md_done && !bus.md_start) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.md_busy = (state_q == ST_BUSY);
    assign bus.stall   = (|w_lu) | (bus.hilo_re & bus.md_busy);

endmodule
`default_nettype wire
